// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential 4-bit ALU responder and its
// iterative multiply/divide datapath.
package alu_pkg;

    localparam int WIDTH = 4;

    localparam logic [1:0] OP_LOGIC = 2'd0;
    localparam logic [1:0] OP_ARITH = 2'd1;
    localparam logic [1:0] OP_SHIFT = 2'd2;

    localparam logic [1:0] F_AND  = 2'd0;
    localparam logic [1:0] F_OR   = 2'd1;
    localparam logic [1:0] F_NAND = 2'd2;
    localparam logic [1:0] F_XOR  = 2'd3;
    localparam logic [1:0] F_ADD  = 2'd0;
    localparam logic [1:0] F_MUL  = 2'd1;
    localparam logic [1:0] F_DIV  = 2'd2;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_e;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] y_hi;
        logic             carry;
        logic             err;
    } rsp_t;

    // Logical shift with zero fill; dir=1 shifts right.
    function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] a,
                                                  input logic [1:0]       amt,
                                                  input logic             dir);
        logic [WIDTH-1:0] r;
        if (dir) begin
            r = a >> amt;
        end else begin
            r = a << amt;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative datapath: WIDTH-step shift-add multiply or restoring divide.
// hi/lo present the accumulator after the current step, valid when done=1.
module alu_muldiv_iter
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_mode_e         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d, step_s;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    md_mode_e           mode_q, mode_d;
    logic [WIDTH:0]     sum_s, rem_s, diff_s;

    // One step: multiply adds b into the high half when the LSB is set then
    // shifts right; divide shifts left and subtracts b when it fits.
    always_comb begin
        sum_s  = '0;
        rem_s  = '0;
        diff_s = '0;
        step_s = acc_q;
        if (mode_q == MD_MUL) begin
            sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
            step_s = {sum_s, acc_q[WIDTH-1:1]};
        end else begin
            rem_s  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
            diff_s = rem_s - {1'b0, opb_q};
            if (diff_s[WIDTH]) begin
                step_s = {rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                step_s = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Load on start, otherwise advance one step per cycle while busy.
    always_comb begin
        acc_d  = acc_q;
        opb_d  = opb_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        mode_d = mode_q;
        if (start) begin
            acc_d  = {{WIDTH{1'b0}}, a};
            opb_d  = b;
            mode_d = mode;
            cnt_d  = CW'(WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d  = step_s;
            cnt_d  = cnt_q - CW'(1);
            busy_d = (cnt_q != '0);
        end else begin
            busy_d = 1'b0;
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            mode_q <= MD_MUL;
        end else begin
            acc_q  <= acc_d;
            opb_q  <= opb_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            mode_q <= mode_d;
        end
    end

    assign done = busy_q && (cnt_q == '0);
    assign hi   = step_s[2*WIDTH-1:WIDTH];
    assign lo   = step_s[WIDTH-1:0];

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU responder: request/response handshakes around single-cycle
// logic/add/shift operators and the shared iterative multiply/divide.
module alu_seq_unit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_opcode,
    input  logic [1:0]       req_func,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_carry_in,
    input  logic [1:0]       req_shift_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [WIDTH-1:0] rsp_y_hi,
    output logic             rsp_carry,
    output logic             rsp_err
);

    state_e           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    rsp_t             rsp_q, rsp_d;
    rsp_t             single_s;
    logic [WIDTH:0]   add_s;
    logic             iter_op_s;
    logic             start_s;
    md_mode_e         md_mode_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_hi_s, md_lo_s;

    // Results of every operation that completes at the accept edge.
    always_comb begin
        single_s = '0;
        add_s    = {1'b0, req_a} + {1'b0, req_b} + {{WIDTH{1'b0}}, req_carry_in};
        case (req_opcode)
            OP_LOGIC: begin
                case (req_func)
                    F_AND:   single_s.y = req_a & req_b;
                    F_OR:    single_s.y = req_a | req_b;
                    F_NAND:  single_s.y = ~(req_a & req_b);
                    F_XOR:   single_s.y = req_a ^ req_b;
                    default: single_s.y = '0;
                endcase
            end
            OP_ARITH: begin
                case (req_func)
                    F_ADD: begin
                        single_s.y     = add_s[WIDTH-1:0];
                        single_s.carry = add_s[WIDTH];
                    end
                    F_MUL: single_s = '0;
                    F_DIV: begin
                        if (req_b == '0) begin
                            single_s.y    = DIV0_QUOTIENT;
                            single_s.y_hi = req_a;
                            single_s.err  = 1'b1;
                        end else begin
                            single_s = '0;
                        end
                    end
                    default: single_s.err = 1'b1;
                endcase
            end
            OP_SHIFT: single_s.y   = shift_op(req_a, req_shift_amt, req_func[0]);
            default:  single_s.err = 1'b1;
        endcase
    end

    assign iter_op_s = (req_opcode == OP_ARITH) &&
                       ((req_func == F_MUL) || ((req_func == F_DIV) && (req_b != '0)));
    assign md_mode_s = (req_func == F_DIV) ? MD_DIV : MD_MUL;

    // Control FSM next state and response register updates.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        start_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (iter_op_s) begin
                        start_s = 1'b1;
                        state_d = ST_CALC;
                    end else begin
                        rsp_d       = single_s;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_CALC: begin
                if (md_done_s) begin
                    rsp_d       = '{y: md_lo_s, y_hi: md_hi_s, carry: 1'b0, err: 1'b0};
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    alu_muldiv_iter u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .mode  (md_mode_s),
        .a     (req_a),
        .b     (req_b),
        .done  (md_done_s),
        .hi    (md_hi_s),
        .lo    (md_lo_s)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_q.y;
    assign rsp_y_hi  = rsp_q.y_hi;
    assign rsp_carry = rsp_q.carry;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed vector table, handshake and
// reset sequences, then randomized operations against a behavioural model.
module tb_alu_seq_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_opcode = 2'd0;
    logic [1:0] req_func = 2'd0;
    logic [3:0] req_a = 4'd0;
    logic [3:0] req_b = 4'd0;
    logic       req_carry_in = 1'b0;
    logic [1:0] req_shift_amt = 2'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_y;
    logic [3:0] rsp_y_hi;
    logic       rsp_carry;
    logic       rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_unit dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opcode    (req_opcode),
        .req_func      (req_func),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_carry_in  (req_carry_in),
        .req_shift_amt (req_shift_amt),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_y         (rsp_y),
        .rsp_y_hi      (rsp_y_hi),
        .rsp_carry     (rsp_carry),
        .rsp_err       (rsp_err)
    );

    typedef struct {
        logic [1:0] op;
        logic [1:0] fn;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [1:0] amt;
        logic [3:0] y;
        logic [3:0] hi;
        logic       c;
        logic       e;
        int         lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model from the operation rules using plain integer arithmetic.
    task automatic ref_model(input logic [1:0] op, input logic [1:0] fn,
                             input logic [3:0] a, input logic [3:0] b,
                             input logic cin, input logic [1:0] amt,
                             output logic [3:0] y, output logic [3:0] hi,
                             output logic c, output logic e, output int lat);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        y = 4'd0; hi = 4'd0; c = 1'b0; e = 1'b0; lat = 1;
        if (op == 2'd0) begin
            if (fn == 2'd0)      r = ia & ib;
            else if (fn == 2'd1) r = ia | ib;
            else if (fn == 2'd2) r = 15 - (ia & ib);
            else                 r = ia ^ ib;
            y = 4'(r);
        end else if (op == 2'd1) begin
            if (fn == 2'd0) begin
                r = ia + ib + int'(cin);
                y = 4'(r % 16);
                c = (r >= 16);
            end else if (fn == 2'd1) begin
                r = ia * ib;
                y = 4'(r % 16);
                hi = 4'(r / 16);
                lat = 5;
            end else if (fn == 2'd2) begin
                if (ib == 0) begin
                    y = 4'd15; hi = a; e = 1'b1;
                end else begin
                    y = 4'(ia / ib); hi = 4'(ia % ib); lat = 5;
                end
            end else begin
                e = 1'b1;
            end
        end else if (op == 2'd2) begin
            if (fn[0]) r = ia / (1 << int'(amt));
            else       r = (ia * (1 << int'(amt))) % 16;
            y = 4'(r);
        end else begin
            e = 1'b1;
        end
    endtask

    // Issue one request, measure latency, check the response, optionally
    // stall rsp_ready for `hold` cycles, then take it.
    task automatic do_op(input logic [1:0] op, input logic [1:0] fn,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic [1:0] amt,
                         input logic [3:0] ey, input logic [3:0] ehi,
                         input logic ec, input logic ee, input int elat,
                         input int hold, input string tag);
        int lat;
        bit got;
        @(negedge clk);
        chk({tag, "_req_ready"}, 8'(req_ready), 8'd1);
        req_valid = 1'b1; req_opcode = op; req_func = fn; req_a = a; req_b = b;
        req_carry_in = cin; req_shift_amt = amt;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_a = ~a; req_b = ~b; req_func = ~fn; req_carry_in = ~cin;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no rsp_valid expected latency %0d", tag, elat);
        end else begin
            n_cmp++;
            if (lat != elat) begin
                n_bad++;
                $display("FAIL %s_latency: got %0d expected %0d", tag, lat, elat);
            end
            chk({tag, "_y"},     8'(rsp_y),     8'(ey));
            chk({tag, "_hi"},    8'(rsp_y_hi),  8'(ehi));
            chk({tag, "_carry"}, 8'(rsp_carry), 8'(ec));
            chk({tag, "_err"},   8'(rsp_err),   8'(ee));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, 8'(rsp_valid), 8'd1);
                chk({tag, "_hold_y"},     8'(rsp_y),     8'(ey));
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_post_valid"}, 8'(rsp_valid), 8'd0);
            chk({tag, "_post_ready"}, 8'(req_ready), 8'd1);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op, fn, amt;
        logic [3:0] a, b, ey, ehi;
        logic       cin, ec, ee;
        int         elat;
        bit         seen;

        //              op    fn    a      b      cin  amt   y      hi     c     e     lat
        vecs[0]  = '{2'd0, 2'd0, 4'hA, 4'hC, 1'b0, 2'd0, 4'h8, 4'h0, 1'b0, 1'b0, 1};
        vecs[1]  = '{2'd0, 2'd3, 4'hF, 4'h1, 1'b0, 2'd0, 4'hE, 4'h0, 1'b0, 1'b0, 1};
        vecs[2]  = '{2'd1, 2'd0, 4'h6, 4'h3, 1'b0, 2'd0, 4'h9, 4'h0, 1'b0, 1'b0, 1};
        vecs[3]  = '{2'd1, 2'd0, 4'h6, 4'h3, 1'b1, 2'd0, 4'hA, 4'h0, 1'b0, 1'b0, 1};
        vecs[4]  = '{2'd1, 2'd0, 4'hF, 4'h1, 1'b1, 2'd0, 4'h1, 4'h0, 1'b1, 1'b0, 1};
        vecs[5]  = '{2'd1, 2'd1, 4'h9, 4'h2, 1'b0, 2'd0, 4'h2, 4'h1, 1'b0, 1'b0, 5};
        vecs[6]  = '{2'd1, 2'd1, 4'hF, 4'hF, 1'b0, 2'd0, 4'h1, 4'hE, 1'b0, 1'b0, 5};
        vecs[7]  = '{2'd1, 2'd2, 4'hA, 4'h2, 1'b0, 2'd0, 4'h5, 4'h0, 1'b0, 1'b0, 5};
        vecs[8]  = '{2'd1, 2'd2, 4'hA, 4'h0, 1'b0, 2'd0, 4'hF, 4'hA, 1'b0, 1'b1, 1};
        vecs[9]  = '{2'd2, 2'd0, 4'hA, 4'h0, 1'b0, 2'd1, 4'h4, 4'h0, 1'b0, 1'b0, 1};
        vecs[10] = '{2'd2, 2'd1, 4'hA, 4'h0, 1'b0, 2'd2, 4'h2, 4'h0, 1'b0, 1'b0, 1};
        vecs[11] = '{2'd3, 2'd0, 4'h5, 4'h3, 1'b1, 2'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1};
        vecs[12] = '{2'd1, 2'd3, 4'h7, 4'h7, 1'b1, 2'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1};
        vecs[13] = '{2'd0, 2'd2, 4'hA, 4'hC, 1'b0, 2'd0, 4'h7, 4'h0, 1'b0, 1'b0, 1};
        vecs[14] = '{2'd2, 2'd2, 4'h3, 4'h0, 1'b0, 2'd3, 4'h8, 4'h0, 1'b0, 1'b0, 1};
        vecs[15] = '{2'd1, 2'd2, 4'h7, 4'h3, 1'b0, 2'd0, 4'h2, 4'h1, 1'b0, 1'b0, 5};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 8'(req_ready), 8'd1);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_y",         8'(rsp_y),     8'd0);
        chk("rst_hi",        8'(rsp_y_hi),  8'd0);
        chk("rst_carry",     8'(rsp_carry), 8'd0);
        chk("rst_err",       8'(rsp_err),   8'd0);

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].amt,
                  vecs[i].y, vecs[i].hi, vecs[i].c, vecs[i].e, vecs[i].lat, 0,
                  $sformatf("vec%0d", i));
        end

        // Backpressure: response held for 3 cycles while a new request is ignored.
        @(negedge clk);
        req_valid = 1'b1; req_opcode = 2'd1; req_func = 2'd0; req_a = 4'h3; req_b = 4'h4;
        req_carry_in = 1'b0;
        @(posedge clk);
        #1 req_opcode = 2'd0; req_a = 4'h0; req_b = 4'h0;
        @(negedge clk);
        chk("bp_valid", 8'(rsp_valid), 8'd1);
        chk("bp_y0",    8'(rsp_y),     8'd7);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk("bp_hold_valid", 8'(rsp_valid), 8'd1);
            chk("bp_hold_y",     8'(rsp_y),     8'd7);
            chk("bp_hold_ready", 8'(req_ready), 8'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk("bp_after_valid", 8'(rsp_valid), 8'd0);
            chk("bp_after_ready", 8'(req_ready), 8'd1);
        end

        // Reset during multiply cycle 2: no response, outputs cleared.
        @(negedge clk);
        req_valid = 1'b1; req_opcode = 2'd1; req_func = 2'd1; req_a = 4'hF; req_b = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_req_ready", 8'(req_ready), 8'd1);
        chk("mrst_y",         8'(rsp_y),     8'd0);
        chk("mrst_hi",        8'(rsp_y_hi),  8'd0);
        seen = 1'b0;
        for (int h = 0; h < 8; h++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("mrst_no_rsp", 8'(seen), 8'd0);
        do_op(2'd1, 2'd1, 4'h3, 4'h5, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0, 1'b0, 5, 1, "mrst_next");

        // Randomized operations with random response stalls.
        for (int n = 0; n < 150; n++) begin
            op  = 2'($urandom_range(0, 3));
            fn  = 2'($urandom_range(0, 3));
            a   = 4'($urandom_range(0, 15));
            b   = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            cin = 1'($urandom_range(0, 1));
            amt = 2'($urandom_range(0, 3));
            ref_model(op, fn, a, b, cin, amt, ey, ehi, ec, ee, elat);
            do_op(op, fn, a, b, cin, amt, ey, ehi, ec, ee, elat,
                  int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Sequential 4-bit ALU responder. It accepts one operation request at a time over a valid/ready handshake and computes the result. Logic, add and shift complete in one cycle; multiply and divide use a shared iterative datapath. It returns the result over a second valid/ready handshake. It is the target end of the stimulus side that drives opcode/operand traffic into the ALU, replacing the free-running combinational operator blocks with a clocked, flow-controlled unit.

## Interface
- WIDTH, 4, operand width; iteration count for mul/div equals WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_opcode  in  2  operation class: 0 logic, 1 arithmetic, 2 shift, 3 reserved.
- req_func  in  2  sub-operation, see Operation.
- req_a  in  WIDTH  operand A / dividend / shift source.
- req_b  in  WIDTH  operand B / divisor.
- req_carry_in  in  1  add carry-in.
- req_shift_amt  in  2  shift amount 0-3.
- rsp_valid  out  1  result present; held until taken.
- rsp_ready  in  1  consumer takes result.
- rsp_y  out  WIDTH  primary result: logic, sum, product low, quotient, or shift.
- rsp_y_hi  out  WIDTH  product high or remainder; 0 for all other operations.
- rsp_carry  out  1  add carry-out; 0 otherwise.
- rsp_err  out  1  divide-by-zero or reserved op.

## Operation
- States: IDLE, CALC, RESP.
  - IDLE: req_ready=1. An accept occurs when req_valid&&req_ready at an edge.
  - On accept: all request fields are latched. Mul and div with a nonzero divisor go to CALC with iter_cnt=WIDTH-1. Every other case computes the result at the accept edge and goes to RESP.
  - CALC: one iteration per cycle. At the edge with iter_cnt==0 the result is registered and the state goes to RESP.
  - RESP: rsp_valid=1 and the outputs are stable. The unit returns to IDLE on rsp_valid&&rsp_ready.
- Logic ops, opcode 0, selected by func: 0 AND, 1 OR, 2 NAND, 3 XOR.
- Arithmetic ops, opcode 1:
  - func 0, add: {rsp_carry,rsp_y} = a+b+carry_in, computed as a (WIDTH+1)-bit sum.
  - func 1, multiply: unsigned shift-add into a 2·WIDTH accumulator. Result is {rsp_y_hi,rsp_y}.
  - func 2, divide: unsigned restoring divide, MSB first. rsp_y=quotient, rsp_y_hi=remainder.
  - func 3: reserved, reported with rsp_err=1.
- Shift ops, opcode 2: req_func[0]=dir, where 0 is a logical left shift and 1 is a logical right shift, by shift_amt with zero fill. req_func[1] is ignored.
- Divide by zero (b==0): result in 1 cycle with rsp_y=4'hF, rsp_y_hi=a, rsp_err=1.
- Reserved op (opcode 3, or opcode 1 with func 3): result in 1 cycle with rsp_y=0, rsp_y_hi=0, rsp_carry=0, rsp_err=1.
- Request inputs are ignored outside IDLE. Only one operation is outstanding at a time.

## Timing
- Reset: state=IDLE; req_ready=1 in the cycle after rst deasserts; rsp_valid=0 and rsp_y=rsp_y_hi=0, rsp_carry=0, rsp_err=0.
- Reset mid-operation: the result is discarded, with no response and no partial-result leak.
- Latency counts from the accept edge at the end of cycle 0:
  - single-cycle ops: rsp_valid high in cycle 1.
  - mul and non-zero div: CALC for cycles 1..WIDTH, rsp_valid high in cycle WIDTH+1, which is cycle 5.
- Backpressure: while rsp_ready=0, RESP holds and all rsp_* outputs are unchanged.
- Response taken in cycle n: rsp_valid=0 and req_ready=1 in cycle n+1. Peak throughput is one single-cycle op per 2 cycles.
- rsp_* values are only meaningful while rsp_valid=1; they are held from the last result otherwise.

## Structure
- Shared package alu_pkg holds:
  - opcode class localparams: OP_LOGIC, OP_ARITH, OP_SHIFT.
  - func localparams: F_AND, F_OR, F_NAND, F_XOR, F_ADD, F_MUL, F_DIV.
  - state encoding: ST_IDLE, ST_CALC, ST_RESP.
  - DIV0_QUOTIENT constant.
- Sub-module alu_muldiv_iter holds the shared accumulator, shift register and iteration counter. Its interface is start, mode, a, b, done, hi and lo. The top level keeps the FSM, the single-cycle operators and the response registers.

## Test plan
- Logic: AND a=1010, b=1100 -> rsp_y=1000 in cycle 1. XOR a=1111, b=0001 -> 1110. rsp_err=0.
- Add: a=0110, b=0011, cin=0 -> y=1001, carry=0. Then cin=1 -> y=1010. Then a=1111, b=0001, cin=1 -> y=0001, carry=1.
- Multiply: a=1001, b=0010 -> hi=0001, lo=0010, rsp_valid first high 5 cycles after accept. Also a=1111, b=1111 -> hi=1110, lo=0001.
- Divide: a=1010, b=0010 -> q=0101, r=0000 at latency 5. a=1010, b=0000 -> q=1111, r=1010, err=1 at latency 1.
- Shift: a=1010, amt=01, dir=0 -> 0100. a=1010, amt=10, dir=1 -> 0010.
- Handshake and reset:
  - hold rsp_ready=0 for 3 cycles -> outputs stable, req_ready=0, and a new req_valid is ignored.
  - assert rst during multiply cycle 2 -> no response, IDLE afterwards.
  - reserved opcode 3 -> err=1, y=0.
